mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side endpoint of the CPU memory interface. Accepts request packets on a decoupled input and returns one response packet per request on a decoupled output.
- Backs requests with an internal word-addressed array, so the core can be simulated and brought up without external memory.
- Provides configurable fixed access latency and a bounded number of outstanding requests, which exercises the core's handshake under back-pressure.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >=4)
- BASE_ADDR, 32'h0, byte address mapped to word 0
- LATENCY, 1, cycles from request accept to response entering the output queue (1..4)
- OUTSTANDING, 2, maximum accepted-but-not-yet-delivered requests; also the response FIFO depth (1..8)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- mem_req  decoupled.in  mem_req_t  request stream; data, valid, ready
- mem_resp  decoupled.out  mem_resp_t  response stream; data, valid, ready

Behaviour:
- Packet formats:
  - mem_req_t = {addr[31:0], wdata[31:0], be[3:0], we}
  - mem_resp_t = {rdata[31:0], err}
- Reset values:
  - mem_req.ready=0, mem_resp.valid=0, mem_resp.data='0.
  - Pipeline, FIFO and credit counter are cleared.
  - Array contents are not reset.
  - A reset mid-operation drops all in-flight requests; no response for them is ever emitted.
- Handshake rules:
  - A transfer occurs on any edge where valid&&ready.
  - mem_req.ready = (inflight < OUTSTANDING), registered. It is never dependent on mem_req.valid.
  - mem_resp.valid is held with stable data until mem_resp.ready.
- inflight counter:
  - Increments on request accept and decrements on response transfer.
  - Simultaneous accept and transfer leaves it unchanged.
  - It never exceeds OUTSTANDING and never underflows.
- Access:
  - Word index = (addr-BASE_ADDR)>>2, taken modulo DEPTH_WORDS.
  - Writes update only the byte lanes with be[i]=1, in the accept cycle.
  - Reads sample the array in the accept cycle, so a read accepted after a write returns the new data.
  - A write produces a response with rdata=0, acting as an acknowledgement.
  - addr[1:0] is ignored.
- Latency:
  - The accepted packet traverses a LATENCY-stage valid/data shift pipeline, then is pushed into the response FIFO.
  - With an empty FIFO, mem_resp.valid rises exactly LATENCY cycles after the accept edge.
  - The credit scheme guarantees the FIFO never overflows, so the pipeline never stalls.
- Ordering: responses are returned strictly in request order.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Push and pop in the same cycle on a full FIFO are legal.
  - Pop on empty never occurs.
- Throughput: with mem_resp.ready held at 1 and OUTSTANDING >= LATENCY+1, the block sustains one request per cycle.

Optional Feature:
- Macro: MEM_RESPONDER_ERR_EN
- When defined, the following are error requests: addr < BASE_ADDR, addr >= BASE_ADDR+4*DEPTH_WORDS, or addr[1:0]!=0.
  - An error request performs no array access (writes suppressed).
  - It returns err=1 and rdata=32'hDEAD_BEEF, with the same latency and ordering as a normal request.
- When not defined, err is constant 0 and the address wraps modulo the array size. No comparator logic is synthesized.

Decomposition:
- Shared package mem_pkg holds:
  - mem_req_t and mem_resp_t packed structs
  - MEM_ERR_RDATA constant (32'hDEAD_BEEF)
  - the width of the be field
- One sub-module: resp_fifo, a parameterised synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty and the same reset style. Instantiate it once for the response queue.

Test Plan:
- Reset release: after reset deasserts, ready=1 on the next cycle and resp.valid=0 → no response is emitted.
- Write then read back, LATENCY=1:
  - Write addr=0x10, wdata=0xA5A5_1234, be=4'hF.
  - Then read addr=0x10.
  - Expected: two responses, the ack (rdata=0, err=0) followed by rdata=0xA5A5_1234. resp.valid rises exactly 1 cycle after each accept.
- Byte enable: word 0x20 holds 0x1111_1111; write wdata=0xFFFF_FFFF with be=4'b0101; read → rdata=0x11FF_11FF.
- Back-pressure, OUTSTANDING=2:
  - Hold resp.ready=0 and offer 3 back-to-back reads of addresses 0x0, 0x4, 0x8.
  - Expected: req.ready=0 after 2 accepts and the third is accepted only after the first response pops. Responses arrive in order and no data changes while stalled.
- Streaming, LATENCY=2, OUTSTANDING=3, resp.ready=1: 16 consecutive reads are accepted with no stall and yield 16 in-order responses matching a preloaded pattern.
- Error path, with MEM_RESPONDER_ERR_EN, DEPTH_WORDS=1024, BASE_ADDR=0:
  - Write to 0x1000, then read 0x1002.
  - Expected: both return err=1 and rdata=0xDEAD_BEEF, and word 0 is unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types for the CPU memory interface: request/response packet layouts,
// the byte-enable width and the read data returned for rejected requests.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int BE_W = 4;

    localparam logic [31:0] MEM_ERR_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic [BE_W-1:0] be;
        logic            we;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

endpackage

// File: rtl/resp_fifo.sv
// -----------------------------------------------------------------------------
// resp_fifo
// Parameterised synchronous circular-buffer FIFO. Push and pop in the same
// cycle are allowed in any state, including full. The caller never pops an
// empty FIFO and never pushes a full one without popping in the same cycle.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset (pointers and count cleared)
//   push_i   write data_i at the tail
//   data_i   [WIDTH-1:0] write data
//   pop_i    drop the head entry
//   data_o   [WIDTH-1:0] head entry (meaningful only when !empty_o)
//   full_o   DEPTH entries held
//   empty_o  no entries held
// -----------------------------------------------------------------------------
module resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push_i && !pop_i)      count_d = count_q + CW'(1);
        else if (!push_i && pop_i) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side endpoint of the CPU memory interface, backed by an internal
// word array. Each accepted request produces exactly one response, in order,
// LATENCY cycles later. At most OUTSTANDING requests are accepted but not yet
// delivered; the response FIFO is sized to match, so it can never overflow and
// the latency pipeline never stalls.
//
// Optional build macro MEM_RESPONDER_ERR_EN: out-of-range or misaligned
// addresses are rejected (no array access, err=1, rdata=MEM_ERR_RDATA).
// Without it err is 0 and addresses wrap modulo the array size.
//
// Ports:
//   clk               clock, rising edge
//   rst               asynchronous active-low reset
//   mem_req_data_i    request packet (mem_req_t)
//   mem_req_valid_i   request valid
//   mem_req_ready_o   request ready (registered, independent of valid)
//   mem_resp_data_o   response packet (mem_resp_t), zero while not valid
//   mem_resp_valid_o  response valid
//   mem_resp_ready_i  response ready
// -----------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          LATENCY     = 1,
    parameter int          OUTSTANDING = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  mem_req_t  mem_req_data_i,
    input  logic      mem_req_valid_i,
    output logic      mem_req_ready_o,
    output mem_resp_t mem_resp_data_o,
    output logic      mem_resp_valid_o,
    input  logic      mem_resp_ready_i
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(OUTSTANDING + 1);

    logic [CW-1:0] inflight_q, inflight_d;
    logic          ready_q;
    logic          accept;
    logic          pop;

    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          req_err;
    mem_resp_t     resp_new;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          push;
    mem_resp_t     push_data;
    mem_resp_t     fifo_dout;
    logic          fifo_empty;
    logic          fifo_full_unused;
    logic          addr_bits_unused;

    assign accept = mem_req_valid_i && ready_q;
    assign pop    = mem_resp_valid_o && mem_resp_ready_i;

    // Credit counter: covers both the latency pipeline and the FIFO.
    always_comb begin
        inflight_d = inflight_q;
        if (accept && !pop)      inflight_d = inflight_q + CW'(1);
        else if (!accept && pop) inflight_d = inflight_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            ready_q    <= (inflight_d < CW'(OUTSTANDING));
        end
    end

    assign mem_req_ready_o = ready_q;

    assign offset = mem_req_data_i.addr - BASE_ADDR;
    assign idx    = offset[AW+1:2];
    assign addr_bits_unused = ^{offset[31:AW+2], offset[1:0]};

`ifdef MEM_RESPONDER_ERR_EN
    localparam logic [32:0] ADDR_END = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

    assign req_err = ({1'b0, mem_req_data_i.addr} <  {1'b0, BASE_ADDR}) ||
                     ({1'b0, mem_req_data_i.addr} >= ADDR_END) ||
                     (mem_req_data_i.addr[1:0] != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    // Read data is the array content before any write of this same cycle;
    // writes only ever return an acknowledgement, so nothing is lost.
    always_comb begin
        resp_new.err = req_err;
        if (req_err)                 resp_new.rdata = MEM_ERR_RDATA;
        else if (mem_req_data_i.we)  resp_new.rdata = '0;
        else                         resp_new.rdata = mem_q[idx];
    end

    always_ff @(posedge clk) begin
        if (accept && mem_req_data_i.we && !req_err) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_req_data_i.be[b]) mem_q[idx][8*b +: 8] <= mem_req_data_i.wdata[8*b +: 8];
            end
        end
    end

    // The FIFO write is the last latency stage, so LATENCY-1 registers sit
    // in front of it; with LATENCY=1 the accept edge writes the FIFO directly.
    if (LATENCY == 1) begin : g_nopipe
        assign push      = accept;
        assign push_data = resp_new;
    end else begin : g_pipe
        logic      pv_q [LATENCY-1];
        mem_resp_t pd_q [LATENCY-1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < LATENCY - 1; i++) begin
                    pv_q[i] <= 1'b0;
                    pd_q[i] <= '0;
                end
            end else begin
                pv_q[0] <= accept;
                pd_q[0] <= resp_new;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pv_q[i] <= pv_q[i-1];
                    pd_q[i] <= pd_q[i-1];
                end
            end
        end

        assign push      = pv_q[LATENCY-2];
        assign push_data = pd_q[LATENCY-2];
    end

    resp_fifo #(
        .WIDTH ($bits(mem_resp_t)),
        .DEPTH (OUTSTANDING)
    ) u_resp_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full_unused),
        .empty_o (fifo_empty)
    );

    assign mem_resp_valid_o = !fifo_empty;
    assign mem_resp_data_o  = mem_resp_valid_o ? fifo_dout : '0;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder. Instance A: LATENCY=1, OUTSTANDING=2.
// Instance B: LATENCY=2, OUTSTANDING=3 (streaming). Both share clock/reset.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_responder;
    import mem_pkg::*;

    logic      clk = 1'b0;
    logic      rst;

    mem_req_t  a_req;
    logic      a_req_v, a_req_r;
    mem_resp_t a_resp;
    logic      a_resp_v, a_resp_r;

    mem_req_t  b_req;
    logic      b_req_v, b_req_r;
    mem_resp_t b_resp;
    logic      b_resp_v, b_resp_r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .DEPTH_WORDS (1024), .BASE_ADDR (32'h0), .LATENCY (1), .OUTSTANDING (2)
    ) dut_a (
        .clk (clk), .rst (rst),
        .mem_req_data_i (a_req), .mem_req_valid_i (a_req_v), .mem_req_ready_o (a_req_r),
        .mem_resp_data_o (a_resp), .mem_resp_valid_o (a_resp_v), .mem_resp_ready_i (a_resp_r)
    );

    mem_responder #(
        .DEPTH_WORDS (1024), .BASE_ADDR (32'h0), .LATENCY (2), .OUTSTANDING (3)
    ) dut_b (
        .clk (clk), .rst (rst),
        .mem_req_data_i (b_req), .mem_req_valid_i (b_req_v), .mem_req_ready_o (b_req_r),
        .mem_resp_data_o (b_resp), .mem_resp_valid_o (b_resp_v), .mem_resp_ready_i (b_resp_r)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mem_req_t mk_req(input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] be, input logic we);
        mem_req_t r;
        r.addr = addr; r.wdata = wdata; r.be = be; r.we = we;
        return r;
    endfunction

    function automatic mem_resp_t mk_resp(input logic [31:0] rdata, input logic err);
        mem_resp_t r;
        r.rdata = rdata; r.err = err;
        return r;
    endfunction

    task automatic wait_a_ready();
        int n = 0;
        while (!a_req_r && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_ready_wait", a_req_r, 1);
    endtask

    // One request on A with resp ready held high; the response must be
    // present in the cycle after acceptance and gone one cycle later.
    task automatic a_single(input string tag, input mem_req_t r, input mem_resp_t e);
        wait_a_ready();
        chk({tag, "_idle"}, a_resp_v, 0);
        a_req   = r;
        a_req_v = 1'b1;
        @(negedge clk);
        a_req_v = 1'b0;
        chk({tag, "_valid"}, a_resp_v, 1);
        chk({tag, "_data"}, a_resp, e);
        @(negedge clk);
        chk({tag, "_drop"}, a_resp_v, 0);
    endtask

    mem_resp_t exp_q[$];
    int        rx;

    initial begin
        rst      = 1'b0;
        a_req    = '0; a_req_v = 1'b0; a_resp_r = 1'b1;
        b_req    = '0; b_req_v = 1'b0; b_resp_r = 1'b1;

        // ---- reset state
        repeat (3) @(negedge clk);
        chk("rst_a_ready", a_req_r, 0);
        chk("rst_a_valid", a_resp_v, 0);
        chk("rst_a_data",  a_resp, 0);
        chk("rst_b_ready", b_req_r, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_a_ready", a_req_r, 1);
        chk("rel_a_valid", a_resp_v, 0);
        chk("rel_b_ready", b_req_r, 1);
        chk("rel_b_valid", b_resp_v, 0);

        // ---- write then read back
        a_single("wr10", mk_req(32'h10, 32'hA5A5_1234, 4'hF, 1'b1), mk_resp(32'h0, 1'b0));
        a_single("rd10", mk_req(32'h10, 32'h0, 4'h0, 1'b0), mk_resp(32'hA5A5_1234, 1'b0));

        // ---- byte enables
        a_single("wr20",   mk_req(32'h20, 32'h1111_1111, 4'hF, 1'b1), mk_resp(32'h0, 1'b0));
        a_single("wr20be", mk_req(32'h20, 32'hFFFF_FFFF, 4'b0101, 1'b1), mk_resp(32'h0, 1'b0));
        a_single("rd20",   mk_req(32'h20, 32'h0, 4'h0, 1'b0), mk_resp(32'h11FF_11FF, 1'b0));

        // ---- back-pressure (OUTSTANDING=2)
        a_single("pre0", mk_req(32'h0, 32'hC0DE_0000, 4'hF, 1'b1), mk_resp(32'h0, 1'b0));
        a_single("pre4", mk_req(32'h4, 32'hC0DE_0001, 4'hF, 1'b1), mk_resp(32'h0, 1'b0));
        a_single("pre8", mk_req(32'h8, 32'hC0DE_0002, 4'hF, 1'b1), mk_resp(32'h0, 1'b0));
        a_resp_r = 1'b0;
        chk("bp_start_ready", a_req_r, 1);
        a_req   = mk_req(32'h0, 32'h0, 4'h0, 1'b0);
        a_req_v = 1'b1;
        @(negedge clk);
        chk("bp_ready1", a_req_r, 1);
        chk("bp_valid1", a_resp_v, 1);
        chk("bp_data1",  a_resp, mk_resp(32'hC0DE_0000, 1'b0));
        a_req = mk_req(32'h4, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        a_req = mk_req(32'h8, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_stall_ready", a_req_r, 0);
            chk("bp_stall_valid", a_resp_v, 1);
            chk("bp_stall_data",  a_resp, mk_resp(32'hC0DE_0000, 1'b0));
            @(negedge clk);
        end
        a_resp_r = 1'b1;
        @(negedge clk);
        chk("bp_pop_ready", a_req_r, 1);
        chk("bp_data2",     a_resp, mk_resp(32'hC0DE_0001, 1'b0));
        a_resp_r = 1'b0;
        @(negedge clk);
        a_req_v = 1'b0;
        chk("bp_full_again", a_req_r, 0);
        chk("bp_hold2",      a_resp, mk_resp(32'hC0DE_0001, 1'b0));
        a_resp_r = 1'b1;
        @(negedge clk);
        chk("bp_valid3", a_resp_v, 1);
        chk("bp_data3",  a_resp, mk_resp(32'hC0DE_0002, 1'b0));
        @(negedge clk);
        chk("bp_empty", a_resp_v, 0);
        chk("bp_ready_end", a_req_r, 1);

        // ---- streaming on B: 16 writes then 16 reads, one per cycle
        rx = 0;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            if (b_resp_v) begin
                if (exp_q.size() == 0) chk("b_extra_resp", 1, 0);
                else chk("b_resp", b_resp, exp_q.pop_front());
                rx++;
            end
            if (c < 32) begin
                chk("b_nostall", b_req_r, 1);
                if (c < 16) begin
                    b_req = mk_req(32'h100 + 32'(4 * c), 32'h5A5A_0000 + 32'(c) * 32'h0001_0011, 4'hF, 1'b1);
                    exp_q.push_back(mk_resp(32'h0, 1'b0));
                end else begin
                    b_req = mk_req(32'h100 + 32'(4 * (c - 16)), 32'h0, 4'h0, 1'b0);
                    exp_q.push_back(mk_resp(32'h5A5A_0000 + 32'(c - 16) * 32'h0001_0011, 1'b0));
                end
                b_req_v = 1'b1;
            end else begin
                b_req_v = 1'b0;
            end
        end
        chk("b_resp_count", rx, 32);
        chk("b_queue_left", exp_q.size(), 0);

`ifdef MEM_RESPONDER_ERR_EN
        // ---- error path
        a_single("err_wr_oob", mk_req(32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b1), mk_resp(32'hDEAD_BEEF, 1'b1));
        a_single("err_rd_mis", mk_req(32'h1002, 32'h0, 4'h0, 1'b0), mk_resp(32'hDEAD_BEEF, 1'b1));
        a_single("err_word0",  mk_req(32'h0, 32'h0, 4'h0, 1'b0), mk_resp(32'hC0DE_0000, 1'b0));
`else
        // ---- address wrap and ignored low bits
        a_single("wrap_rd",   mk_req(32'h1000, 32'h0, 4'h0, 1'b0), mk_resp(32'hC0DE_0000, 1'b0));
        a_single("lowbit_rd", mk_req(32'h12, 32'h0, 4'h0, 1'b0), mk_resp(32'hA5A5_1234, 1'b0));
`endif

        // ---- reset while a response is queued
        a_resp_r = 1'b0;
        wait_a_ready();
        a_req   = mk_req(32'h10, 32'h0, 4'h0, 1'b0);
        a_req_v = 1'b1;
        @(negedge clk);
        a_req_v = 1'b0;
        chk("mid_queued", a_resp_v, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", a_resp_v, 0);
        chk("mid_rst_ready", a_req_r, 0);
        chk("mid_rst_data",  a_resp, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", a_req_r, 1);
        a_resp_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("mid_no_resp", a_resp_v, 0);
            @(negedge clk);
        end
        a_single("mid_keep", mk_req(32'h10, 32'h0, 4'h0, 1'b0), mk_resp(32'hA5A5_1234, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
